// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: ROM port, redirect and decode handshake bundle for the fetch unit.
// master = fetch unit side, slave = ROM/decode/branch side.
interface instruction_fetch_unit_if;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        br_valid;
    logic [31:0] br_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_done;
    modport master (
        output rom_addr, if_valid, if_instr, if_pc, if_done,
        input  rom_data, br_valid, br_target, if_ready
    );
    modport slave (
        input  rom_addr, if_valid, if_instr, if_pc, if_done,
        output rom_data, br_valid, br_target, if_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: one-word-per-cycle ROM fetch into a 2-entry {pc, instr} FIFO with redirect.
// Optional FETCH_PERF_CNT_EN adds a saturating accepted-instruction counter on fetch_count.
module instruction_fetch_unit #(
    parameter int          PROG_LEN = 12,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic clka,
    input  logic rst_n,
    instruction_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);
    typedef enum logic [1:0] {FETCH, HALT, DONE} state_t;
    localparam logic [31:0] LEN = 32'(PROG_LEN);
    state_t      state;
    logic [31:0] req_pc;
    logic [31:0] inflight_pc;
    logic        inflight;
    logic [31:0] fifo_pc [2];
    logic [31:0] fifo_instr [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        pop;
    logic        in_range;
    logic        tgt_in_range;
    logic        issue;
    logic [2:0]  occ;
    logic        unused_bits;
    assign unused_bits  = ^bus.br_target[1:0];
    assign pop          = (count != 2'd0) && bus.if_ready;
    assign in_range     = {2'b00, req_pc[31:2]} < LEN;
    assign tgt_in_range = {2'b00, bus.br_target[31:2]} < LEN;
    // Occupancy counts the word in flight so a full FIFO never gets overrun.
    assign occ          = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue        = (state == FETCH) && in_range && (occ < 3'd2);
    assign bus.if_valid = count != 2'd0;
    assign bus.if_instr = fifo_instr[rd_ptr];
    assign bus.if_pc    = fifo_pc[rd_ptr];
    assign bus.if_done  = state == DONE;
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            req_pc        <= RESET_PC;
            inflight_pc   <= 32'h0;
            inflight      <= 1'b0;
            bus.rom_addr  <= RESET_PC[7:2];
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            fifo_pc[0]    <= 32'h0;
            fifo_pc[1]    <= 32'h0;
            fifo_instr[0] <= 32'h0;
            fifo_instr[1] <= 32'h0;
        end else if (bus.br_valid) begin
            // Redirect wins over issue, capture and pop; the in-flight word is dropped.
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            inflight <= 1'b0;
            req_pc   <= {bus.br_target[31:2], 2'b00};
            state    <= tgt_in_range ? FETCH : HALT;
        end else begin
            if (inflight) begin
                fifo_pc[wr_ptr]    <= inflight_pc;
                fifo_instr[wr_ptr] <= bus.rom_data;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count    <= count + {1'b0, inflight} - {1'b0, pop};
            inflight <= issue;
            if (issue) begin
                bus.rom_addr <= req_pc[7:2];
                inflight_pc  <= req_pc;
                req_pc       <= req_pc + 32'd4;
            end
            state <= (state == FETCH && !in_range) ? HALT :
                     (state == HALT && count == 2'd0 && !inflight) ? DONE : state;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n)
            fetch_count <= 16'h0;
        else if (pop && !bus.br_valid && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus with a queue scoreboard checked by a separate monitor.
module tb_instruction_fetch_unit;
    localparam logic [31:0] PROG [12] = '{
        32'h13a0000c, 32'he3a01004, 32'he0812000, 32'he2522001,
        32'h1afffffd, 32'he3a03064, 32'he5803000, 32'he5803004,
        32'he1a04003, 32'he0445003, 32'he3550000, 32'he1016090
    };
    logic clka;
    logic rst_n;
    logic [31:0] rom [64];
    logic [63:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    instruction_fetch_unit_if bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
`endif
    instruction_fetch_unit #(.PROG_LEN(12), .RESET_PC(32'h0)) dut (
        .clka (clka),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );
    initial clka = 1'b0;
    always #5 clka = ~clka;
    // ROM model: read data latched on the falling edge.
    always @(negedge clka) bus.rom_data <= rom[bus.rom_addr];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Monitor: every accepted instruction must match the scoreboard head.
    always @(negedge clka) begin
        if (rst_n && bus.if_valid && bus.if_ready && !bus.br_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h instr %h expected none", bus.if_pc, bus.if_instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("if_pc", bus.if_pc, e[63:32]);
                chk("if_instr", bus.if_instr, e[31:0]);
            end
        end
    end
    task automatic cyc();
        @(posedge clka);
        #1;
    endtask
    task automatic push_exp(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            exp_q.push_back({32'(i * 4), PROG[i]});
    endtask
    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clka);
        rst_n = 1'b1;
    endtask
    task automatic run(input logic [3:0] pat);
        for (int k = 0; k < 300; k++) begin
            bus.if_ready = pat[k % 4];
            cyc();
            if (bus.if_done) break;
        end
        chk("run_done", {31'h0, bus.if_done}, 32'h1);
        chk("run_valid_low", {31'h0, bus.if_valid}, 32'h0);
        chk("run_drained", exp_q.size(), 32'h0);
        exp_q.delete();
    endtask
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hffff0000 | 32'(i);
        for (int i = 0; i < 12; i++) rom[i] = PROG[i];
        rst_n = 1'b0;
        bus.if_ready = 1'b0;
        bus.br_valid = 1'b0;
        bus.br_target = 32'h0;
        #3;
        chk("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_done", {31'h0, bus.if_done}, 32'h0);
        chk("rst_instr", bus.if_instr, 32'h0);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_rom_addr", {26'h0, bus.rom_addr}, 32'h0);
        // Latency after reset release, then free run to completion.
        push_exp(0, 11);
        bus.if_ready = 1'b1;
        @(negedge clka);
        rst_n = 1'b1;
        cyc();
        chk("edge1_valid", {31'h0, bus.if_valid}, 32'h0);
        cyc();
        chk("edge2_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("edge2_pc", bus.if_pc, 32'h0);
        run(4'b1111);
        // Stall with decode not ready: FIFO holds pc 0 and 4, issue stops.
        bus.if_ready = 1'b0;
        apply_reset();
        repeat (7) cyc();
        chk("stall_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("stall_pc", bus.if_pc, 32'h0);
        chk("stall_instr", bus.if_instr, 32'h13a0000c);
        chk("stall_rom_addr", {26'h0, bus.rom_addr}, 32'h1);
        push_exp(0, 11);
        run(4'b0101);
        // Redirect while the FIFO is full.
        bus.if_ready = 1'b0;
        apply_reset();
        repeat (4) cyc();
        bus.br_valid = 1'b1;
        bus.br_target = 32'h1E;
        cyc();
        bus.br_valid = 1'b0;
        chk("flush_valid", {31'h0, bus.if_valid}, 32'h0);
        push_exp(7, 11);
        run(4'b1111);
        // Redirect accepted from DONE.
        bus.br_valid = 1'b1;
        bus.br_target = 32'h28;
        cyc();
        bus.br_valid = 1'b0;
        chk("redir_done_clear", {31'h0, bus.if_done}, 32'h0);
        push_exp(10, 11);
        run(4'b0011);
        // Out-of-range redirect goes straight through HALT to DONE.
        bus.br_valid = 1'b1;
        bus.br_target = 32'h100;
        cyc();
        bus.br_valid = 1'b0;
        repeat (3) cyc();
        chk("oor_done", {31'h0, bus.if_done}, 32'h1);
        chk("oor_valid", {31'h0, bus.if_valid}, 32'h0);
        // Asynchronous reset mid-stall with two entries buffered.
        bus.if_ready = 1'b0;
        apply_reset();
        repeat (4) cyc();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("mid_rst_pc", bus.if_pc, 32'h0);
        chk("mid_rst_instr", bus.if_instr, 32'h0);
        chk("mid_rst_rom_addr", {26'h0, bus.rom_addr}, 32'h0);
        chk("mid_rst_done", {31'h0, bus.if_done}, 32'h0);
        @(negedge clka);
        rst_n = 1'b1;
        push_exp(0, 11);
        run(4'b1111);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", {16'h0, fetch_count}, 32'd12);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter PROG_LEN, default 12: number of valid instruction words in ROM.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: byte address of the first fetch.
REQ-003 SHALL have port clka, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rom_addr, output, 6: ROM word address, registered.
REQ-006 SHALL have port rom_data, input, 32: ROM read data, latched by ROM on falling edge of clka.
REQ-007 SHALL have port br_valid, input, 1: redirect request.
REQ-008 SHALL have port br_target, input, 32: redirect byte address.
REQ-009 SHALL have port if_valid, output, 1: instruction available to decode.
REQ-010 SHALL have port if_ready, input, 1: decode accepts.
REQ-011 SHALL have port if_instr, output, 32: instruction word.
REQ-012 SHALL have port if_pc, output, 32: byte address of if_instr.
REQ-013 SHALL have port if_done, output, 1: program exhausted and fully drained.

Function
REQ-014 SHALL keep byte PC req_pc with bits [1:0] always 0; rom_addr = req_pc[7:2].
REQ-015 SHALL, on an issue edge, drive rom_addr for the issued word and set inflight=1; on the next rising edge it SHALL capture {req_pc, rom_data} into the output FIFO.
REQ-016 SHALL sustain one issue per cycle; req_pc += 4 per issue.
REQ-017 SHALL use a 2-entry FIFO of {pc, instr}; if_valid = FIFO not empty; head drives if_instr/if_pc.
REQ-018 SHALL pop the head when if_valid && if_ready.
REQ-019 SHALL issue only if (fifo_count + inflight - pop) < 2; full FIFO stalls issue, never drops data.
REQ-020 SHALL implement FSM states FETCH, HALT, DONE.
REQ-021 FETCH SHALL move to HALT when req_pc[31:2] >= PROG_LEN; no issue in HALT.
REQ-022 HALT SHALL move to DONE when FIFO empty and inflight=0; if_done = (state == DONE).
REQ-023 br_valid SHALL have priority over issue, pop and capture in the same cycle: flush FIFO, discard inflight data, req_pc = {br_target[31:2],2'b00}, state = FETCH (or HALT if out of range).
REQ-024 First post-redirect issue SHALL occur on the edge after br_valid is sampled; br_valid SHALL be accepted in any state, including DONE.
REQ-025 SHALL wrap fifo pointers modulo 2; simultaneous capture and pop on a full FIFO SHALL be allowed.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear FIFO, inflight, if_valid=0, if_done=0, if_instr=0, if_pc=0, rom_addr=RESET_PC[7:2], req_pc=RESET_PC, state=FETCH.
REQ-027 First issue SHALL occur on the first rising edge after rst_n release; reset mid-fetch SHALL discard all pending data.

Configuration
REQ-028 With FETCH_PERF_CNT_EN defined, SHALL add output fetch_count[15:0] counting accepted instructions (pop), saturating at 16'hFFFF, cleared by reset and not by br_valid.
REQ-029 Without FETCH_PERF_CNT_EN, port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset release, if_ready=1 -> if_valid after 2nd rising edge, if_instr=32'h13a0000c, if_pc=0; next cycle 32'he3a01004, if_pc=4.
REQ-031 if_ready=0 for 5 cycles after first valid -> FIFO holds pc 0 and 4, rom_addr stops advancing, no loss; release returns 0,4,8 in order.
REQ-032 br_valid with br_target=32'h1E while FIFO full -> FIFO flushed, next if_pc=32'h1C, if_instr=32'he5803004.
REQ-033 Free run with PROG_LEN=12 -> 12 instructions, last 32'he1016090 at pc 32'h2C, then if_done=1, if_valid=0.
REQ-034 rst_n low during stall with 2 entries -> outputs cleared immediately; refetch from pc 0 after release.
REQ-035 With FETCH_PERF_CNT_EN, REQ-033 run -> fetch_count=12; with a redirect mid-run -> count equals accepted instructions only.
